// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_pred_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  // Tag field is sized for the smallest table; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int unsigned idxw);
    return 30'(pc >> (idxw + 32'd2));
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter next-state function.
module bp_sat_ctr
  import branch_pred_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  // saturating step toward strongly-taken or strongly-not-taken
  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      else               ctr_next = ctr;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      else                ctr_next = ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch prediction,
// resolve-time training and a registered one-cycle redirect pulse.
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] fetch_pc_in,
  output logic        pred_taken_out,
  output logic [31:0] pred_target_out,
  input  logic        res_valid_in,
  input  logic [31:0] res_pc_in,
  input  logic        res_is_ctrl_in,
  input  logic        res_taken_in,
  input  logic [31:0] res_target_in,
  input  logic        res_pred_taken_in,
  input  logic [31:0] res_pred_target_in,
  output logic        mispredict_out,
  output logic [31:0] redirect_pc_out
);

  localparam int IDXW = $clog2(ENTRIES);

  bp_entry_t         tbl_r [ENTRIES];
  logic [IDXW-1:0]   f_idx_s;
  bp_entry_t         f_ent_s;
  logic              f_hit_s;
  logic [IDXW-1:0]   r_idx_s;
  bp_entry_t         r_ent_s;
  logic              r_hit_s;
  logic [1:0]        ctr_next_s;
  logic              wr_en_s;
  bp_entry_t         wr_ent_s;
  logic              mis_s;
  logic [31:0]       redir_s;

  assign f_idx_s = fetch_pc_in[IDXW+1:2];
  assign f_ent_s = tbl_r[f_idx_s];
  assign f_hit_s = f_ent_s.valid && (f_ent_s.tag == pc_tag(fetch_pc_in, IDXW));
  assign r_idx_s = res_pc_in[IDXW+1:2];
  assign r_ent_s = tbl_r[r_idx_s];
  assign r_hit_s = r_ent_s.valid && (r_ent_s.tag == pc_tag(res_pc_in, IDXW));

  bp_sat_ctr u_sat_ctr (
    .ctr      (r_ent_s.ctr),
    .inc      (res_taken_in),
    .ctr_next (ctr_next_s)
  );

  // fetch-side prediction straight from the registered table (no bypass)
  always_comb begin
    pred_taken_out  = f_hit_s && f_ent_s.ctr[1];
    pred_target_out = fetch_pc_in + 32'd4;
    if (pred_taken_out) pred_target_out = f_ent_s.target;
    else                pred_target_out = fetch_pc_in + 32'd4;
  end

  // training write, alias invalidation and mispredict detection
  always_comb begin
    wr_en_s  = 1'b0;
    wr_ent_s = r_ent_s;
    mis_s    = 1'b0;
    redir_s  = res_pc_in + 32'd4;
    if (res_valid_in) begin
      mis_s = (res_pred_taken_in != res_taken_in)
           || (res_pred_taken_in && res_taken_in && (res_pred_target_in != res_target_in))
           || (!res_is_ctrl_in && res_pred_taken_in);
      if (res_is_ctrl_in && res_taken_in) redir_s = res_target_in;
      else                                redir_s = res_pc_in + 32'd4;
      if (res_is_ctrl_in) begin
        if (r_hit_s) begin
          wr_en_s      = 1'b1;
          wr_ent_s.ctr = ctr_next_s;
          if (res_taken_in) wr_ent_s.target = res_target_in;
          else              wr_ent_s.target = r_ent_s.target;
        end else if (res_taken_in) begin
          wr_en_s  = 1'b1;
          wr_ent_s = '{valid: 1'b1, tag: pc_tag(res_pc_in, IDXW),
                       target: res_target_in, ctr: CTR_ALLOC};
        end else begin
          wr_en_s = 1'b0;
        end
      end else if (res_pred_taken_in && r_hit_s) begin
        wr_en_s        = 1'b1;
        wr_ent_s.valid = 1'b0;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      mis_s = 1'b0;
    end
  end

  // table and redirect registers; redirect PC holds between pulses
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_r[i] <= '{valid: 1'b0, tag: 30'd0, target: 32'd0, ctr: CTR_RESET};
      end
      mispredict_out  <= 1'b0;
      redirect_pc_out <= 32'd0;
    end else begin
      if (wr_en_s) tbl_r[r_idx_s] <= wr_ent_s;
      mispredict_out <= mis_s;
      if (mis_s) redirect_pc_out <= redir_s;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a table model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] fetch_pc_in;
  logic        pred_taken_out;
  logic [31:0] pred_target_out;
  logic        res_valid_in;
  logic [31:0] res_pc_in;
  logic        res_is_ctrl_in;
  logic        res_taken_in;
  logic [31:0] res_target_in;
  logic        res_pred_taken_in;
  logic [31:0] res_pred_target_in;
  logic        mispredict_out;
  logic [31:0] redirect_pc_out;

  int checks = 0;
  int errors = 0;

  // reference model: per-slot valid/tag/target and a counter kept as an integer 0..3
  logic        m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic        exp_mis;
  logic [31:0] exp_redir;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .fetch_pc_in(fetch_pc_in),
    .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out),
    .res_valid_in(res_valid_in), .res_pc_in(res_pc_in), .res_is_ctrl_in(res_is_ctrl_in),
    .res_taken_in(res_taken_in), .res_target_in(res_target_in),
    .res_pred_taken_in(res_pred_taken_in), .res_pred_target_in(res_pred_target_in),
    .mispredict_out(mispredict_out), .redirect_pc_out(redirect_pc_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = int'((pc / 32'd4) % ENTRIES);
    t  = m_valid[i] && (m_tag[i] == pc / (32'd4 * ENTRIES)) && (m_ctr[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endfunction

  task automatic set_res(input logic v, input logic [31:0] pc, input logic ctrl, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    res_valid_in = v; res_pc_in = pc; res_is_ctrl_in = ctrl; res_taken_in = tk;
    res_target_in = tgt; res_pred_taken_in = ptk; res_pred_target_in = ptgt;
  endtask

  // advance one clock, applying the spec's rules to the model with the current inputs
  task automatic do_cycle();
    int i;
    logic hit;
    logic [31:0] tag;
    i   = int'((res_pc_in / 32'd4) % ENTRIES);
    tag = res_pc_in / (32'd4 * ENTRIES);
    hit = m_valid[i] && (m_tag[i] == tag);
    if (reset_in) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; end
      exp_mis = 1'b0; exp_redir = 32'd0;
    end else if (res_valid_in) begin
      exp_mis = (res_pred_taken_in != res_taken_in)
             || (res_pred_taken_in && res_taken_in && res_pred_target_in != res_target_in)
             || (!res_is_ctrl_in && res_pred_taken_in);
      if (exp_mis) exp_redir = (res_is_ctrl_in && res_taken_in) ? res_target_in : res_pc_in + 32'd4;
      if (res_is_ctrl_in) begin
        if (hit) begin
          m_ctr[i] = res_taken_in ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                  : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (res_taken_in) m_target[i] = res_target_in;
        end else if (res_taken_in) begin
          m_valid[i] = 1'b1; m_tag[i] = tag; m_target[i] = res_target_in; m_ctr[i] = 2;
        end
      end else if (res_pred_taken_in && hit) begin
        m_valid[i] = 1'b0;
      end
    end else begin
      exp_mis = 1'b0;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; fetch_pc_in = 32'h100;
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    do_cycle(); do_cycle();
    reset_in = 1'b0; #1;
    checks++; if (pred_taken_out !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken_out); end
    checks++; if (pred_target_out !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h want 00000104", pred_target_out); end
    checks++; if (mispredict_out !== 1'b0 || redirect_pc_out !== 32'd0) begin errors++; $display("FAIL reset_outputs got mis=%0b redir=%h want 0/0", mispredict_out, redirect_pc_out); end
  endtask

  task automatic test_taken_alloc();
    set_res(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    do_cycle();
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h80) begin errors++; $display("FAIL alloc_redirect got mis=%0b redir=%h want 1/00000080", mispredict_out, redirect_pc_out); end
    fetch_pc_in = 32'h100; #1;
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h80) begin errors++; $display("FAIL alloc_predict got %0b/%h want 1/00000080", pred_taken_out, pred_target_out); end
    do_cycle();
    checks++; if (mispredict_out !== 1'b0) begin errors++; $display("FAIL pulse_width got %0b want 0", mispredict_out); end
  endtask

  task automatic test_train_down();
    fetch_pc_in = 32'h100;
    set_res(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    do_cycle();
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h104) begin errors++; $display("FAIL nt_redirect got mis=%0b redir=%h want 1/00000104", mispredict_out, redirect_pc_out); end
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h104) begin errors++; $display("FAIL nt_predict got %0b/%h want 0/00000104", pred_taken_out, pred_target_out); end
    set_res(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    do_cycle();
    checks++; if (mispredict_out !== 1'b0) begin errors++; $display("FAIL nt_correct got mis=%0b want 0", mispredict_out); end
    // counter now strongly not-taken: one taken outcome must not flip the prediction
    set_res(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    do_cycle();
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (pred_taken_out !== 1'b0) begin errors++; $display("FAIL sat_low got %0b want 0", pred_taken_out); end
  endtask

  task automatic test_alias();
    set_res(1'b1, 32'h140, 1'b1, 1'b1, 32'h200, 1'b0, 32'h144);
    do_cycle();
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    fetch_pc_in = 32'h100; #1;
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h104) begin errors++; $display("FAIL alias_old got %0b/%h want 0/00000104", pred_taken_out, pred_target_out); end
    fetch_pc_in = 32'h140; #1;
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h200) begin errors++; $display("FAIL alias_new got %0b/%h want 1/00000200", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_same_cycle();
    fetch_pc_in = 32'h140;
    set_res(1'b1, 32'h140, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h200) begin errors++; $display("FAIL same_cycle_old got %0b/%h want 1/00000200", pred_taken_out, pred_target_out); end
    do_cycle();
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); #1;
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h144) begin errors++; $display("FAIL same_cycle_new got %0b/%h want 0/00000144", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_wrap();
    fetch_pc_in = 32'hFFFF_FFFC;
    set_res(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
    do_cycle();
    set_res(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h20, 1'b1, 32'h10);
    do_cycle();
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h20) begin errors++; $display("FAIL jal_target got mis=%0b redir=%h want 1/00000020", mispredict_out, redirect_pc_out); end
    checks++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h20) begin errors++; $display("FAIL jal_retarget got %0b/%h want 1/00000020", pred_taken_out, pred_target_out); end
    set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    do_cycle();
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); #1;
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h0) begin errors++; $display("FAIL nonctrl_wrap got mis=%0b redir=%h want 1/00000000", mispredict_out, redirect_pc_out); end
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h0) begin errors++; $display("FAIL nonctrl_inval got %0b/%h want 0/00000000", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_back_to_back();
    set_res(1'b1, 32'h180, 1'b1, 1'b1, 32'h40, 1'b0, 32'h184);
    do_cycle();
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h40) begin errors++; $display("FAIL b2b_first got mis=%0b redir=%h want 1/00000040", mispredict_out, redirect_pc_out); end
    set_res(1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    do_cycle();
    checks++; if (mispredict_out !== 1'b1 || redirect_pc_out !== 32'h1C4) begin errors++; $display("FAIL b2b_second got mis=%0b redir=%h want 1/000001c4", mispredict_out, redirect_pc_out); end
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    do_cycle();
    checks++; if (mispredict_out !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b want 0", mispredict_out); end
  endtask

  task automatic test_reset_with_resolve();
    reset_in = 1'b1;
    set_res(1'b1, 32'h180, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
    do_cycle();
    reset_in = 1'b0;
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    fetch_pc_in = 32'h180; #1;
    checks++; if (mispredict_out !== 1'b0 || redirect_pc_out !== 32'd0) begin errors++; $display("FAIL reset_wins got mis=%0b redir=%h want 0/0", mispredict_out, redirect_pc_out); end
    checks++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h184) begin errors++; $display("FAIL reset_clears got %0b/%h want 0/00000184", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_random();
    logic        et;
    logic [31:0] etg;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      reset_in    = ($urandom_range(0, 60) == 0);
      fetch_pc_in = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      if ($urandom_range(0, 15) == 0) fetch_pc_in = 32'hFFFF_FFFC;
      pc = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      set_res(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC, 1'b0, 32'd0);
      model_pred(pc, et, etg);
      if ($urandom_range(0, 3) != 0) begin
        res_pred_taken_in = et; res_pred_target_in = etg;
      end else begin
        res_pred_taken_in = 1'($urandom_range(0, 1)); res_pred_target_in = {$urandom} & 32'hFFFF_FFFC;
      end
      #1;
      model_pred(fetch_pc_in, et, etg);
      checks++; if (pred_taken_out !== et || pred_target_out !== etg) begin errors++; $display("FAIL rand_pred n=%0d pc=%h got %0b/%h want %0b/%h", n, fetch_pc_in, pred_taken_out, pred_target_out, et, etg); end
      do_cycle();
      checks++; if (mispredict_out !== exp_mis || (exp_mis && redirect_pc_out !== exp_redir)) begin errors++; $display("FAIL rand_mis n=%0d got %0b/%h want %0b/%h", n, mispredict_out, redirect_pc_out, exp_mis, exp_redir); end
    end
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in = 1'b1;
    fetch_pc_in = 32'd0;
    set_res(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    exp_mis = 1'b0; exp_redir = 32'd0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = 32'd0; m_target[k] = 32'd0; m_ctr[k] = 1;
    end
    @(posedge clk_in); #1;
    test_reset();
    test_taken_alloc();
    test_train_down();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_back_to_back();
    test_reset_with_resolve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
